// File: rtl/pipo_load_arbiter_pkg.sv
// pipo_arb_pkg: shared types, default parameters and helpers for the load arbiter.
// Provides the FSM state enum, parameter defaults and a one-hot helper.
package pipo_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;
    localparam int HOLD_DEF  = 2;
    localparam int MAX_REQ   = 8;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
        logic [MAX_REQ-1:0] v;
        v = '0;
        v[idx[2:0]] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pipo_load_arbiter_if.sv
// pipo_load_arbiter_if: requester bus (req/data in, gnt/q/owner/valid/busy out).
// master = requester side, slave = arbiter side.
interface pipo_load_arbiter_if
    import pipo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] data;
    logic [N_REQ-1:0]   gnt;
    logic [W-1:0]       q;
    logic [IW-1:0]      owner;
    logic               valid;
    logic               busy;

    modport master (
        output req, data,
        input  gnt, q, owner, valid, busy
    );

    modport slave (
        input  req, data,
        output gnt, q, owner, valid, busy
    );

endinterface

// File: rtl/pipo_load_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports: req (requests), ptr (search start) -> win (index), any (some req set).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    win,
    output logic             any
);

    int idx;

    // Scan from ptr upward with wrap; first hit wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: N requesters share one W-bit holding register, RR arbitration,
// HOLD-cycle lock after each load. Ports: clk, rst (async low), clr (sync), bus (slave).
// Option PIPO_ARB_FIXED_PRIO_EN: lowest index wins, no rr pointer.
module pipo_load_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int HOLD  = HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    pipo_load_arbiter_if.slave bus
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [3:0]         cnt;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      win;
    logic               any;
    logic [MAX_REQ-1:0] oh8;
    logic [N_REQ-1:0]   win_oh;
    logic [W-1:0]       win_data;
    logic               load;

    rr_pick #(
        .N_REQ(N_REQ),
        .IW   (IW)
    ) u_pick (
        .req(bus.req),
        .ptr(ptr),
        .win(win),
        .any(any)
    );

    assign oh8      = onehot(int'(win));
    assign win_oh   = oh8[N_REQ-1:0];
    assign win_data = bus.data[int'(win)*W +: W];
    assign load     = (state == ST_IDLE) && any && !clr;

`ifdef PIPO_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Pointer survives clr so fairness carries across clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bus.q     <= '0;
            bus.owner <= '0;
            bus.valid <= 1'b0;
            bus.gnt   <= '0;
            bus.busy  <= 1'b0;
        end else if (clr) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bus.q     <= '0;
            bus.owner <= '0;
            bus.valid <= 1'b0;
            bus.gnt   <= '0;
            bus.busy  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    bus.gnt <= '0;
                    if (any) begin
                        bus.q     <= win_data;
                        bus.owner <= win;
                        bus.valid <= 1'b1;
                        bus.gnt   <= win_oh;
                        bus.busy  <= 1'b1;
                        cnt       <= 4'(HOLD - 1);
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    bus.gnt <= '0;
                    if (cnt == 4'd0) begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Shares one W-bit parallel-in/parallel-out holding register between N requesters. Each cycle it can pick one pending requester (round-robin) and load that requester's data word into the register, pulse a one-hot grant back to it, and record who owns the current contents. A programmable hold window after every load keeps the value stable for downstream consumers before the next load is accepted.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W, 4, data width of each requester word and of the register
- HOLD, 2, cycles the register is locked after a load (1..15)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of register contents and FSM
- req  input  N_REQ  per-requester load request, level
- data  input  N_REQ*W  requester words; requester i at bits [i*W +: W]
- gnt  output  N_REQ  one-hot grant pulse, registered
- q  output  W  holding register contents
- owner  output  $clog2(N_REQ)  index of requester whose word is in q
- valid  output  1  q holds a loaded word (not reset/cleared value)
- busy  output  1  hold window active; new requests not sampled

## Operation
- Reset (rst low, asynchronous): q=0, owner=0, valid=0, gnt=0, busy=0, state=IDLE, rr pointer=0, hold counter=0.
- States: IDLE, HOLD.
- IDLE, no req: nothing changes, gnt=0.
- IDLE, |req at rising edge: winner = first set req bit searching from rr pointer upward, wrapping. On that edge: q<=data[winner], owner<=winner, valid<=1, gnt<=onehot(winner), pointer<=(winner+1) mod N_REQ, counter<=HOLD-1, state<=HOLD.
- HOLD: busy=1, gnt=0 after the first cycle, req ignored. Counter decrements each edge; at edge with counter==0 state<=IDLE.
- clr high at an edge: q<=0, valid<=0, owner<=0, gnt<=0, state<=IDLE, counter<=0; rr pointer kept. clr overrides a simultaneous grant.
- Requester protocol: hold req and data stable until gnt[i] seen; drop req in the cycle gnt[i] is high unless another load is wanted. A req still high after the hold window re-arbitrates normally.
- Round-robin guarantees any continuously asserted req is granted within N_REQ loads.

## Timing
- req sampled at edge k (state IDLE) -> q, owner, valid, gnt valid after edge k; gnt high exactly one cycle (k..k+1).
- busy high from edge k through edge k+HOLD; earliest next load at edge k+HOLD+1.
- Load-to-load minimum spacing: HOLD+1 cycles. Throughput with all req high: one load per HOLD+1 cycles.
- No combinational path from req/data to any output.

## Configuration
- PIPO_ARB_FIXED_PRIO_EN defined: winner is the lowest set req index; rr pointer removed (not updated, not used). Starvation of high indices is permitted.
- Undefined (default): round-robin as described.

## Structure
- Package pipo_arb_pkg: state enum (IDLE, HOLD), default parameter constants, onehot/index helper function.
- Sub-module rr_pick: combinational picker (req, pointer -> winner index, any). Fixed-priority build drives pointer=0.

## Test plan
- Reset mid-HOLD: after load of 4'hA, assert rst low -> q=0, valid=0, busy=0, gnt=0 immediately, IDLE after release.
- Single request: req=4'b0100, data[2]=4'h5 -> after edge q=5, owner=2, gnt=4'b0100 for one cycle, busy for 2 cycles.
- All requesters high, data i=i+1, HOLD=2 -> grants 0,1,2,3,0 every 3 cycles; q sequence 1,2,3,4,1.
- Pointer wrap: last grant 3, req=4'b1001 -> next grant 0, then 3.
- clr coinciding with IDLE req=4'b0010 -> no gnt, q=0, valid=0; grant to 1 on following edge.
- PIPO_ARB_FIXED_PRIO_EN build, req=4'b1011 held -> grants 0 every HOLD+1 cycles; req 1, 3 never granted.
